// File: rtl/countdown_timer.sv
// countdown_timer: down-counting mm:ss timer with expiry flag.
//
// A duration is loaded, counted down once per second (every TICKS_PER_SEC
// clk cycles) while running, and on reaching 00:00 the timer enters EXPIRED
// and raises done for exactly one cycle. Output widths match the stopwatch
// so both blocks can share the display path.
//
// Ports:
//   clk       in   1  system clock, rising edge
//   rst       in   1  asynchronous active-high reset
//   load      in   1  strobe: capture load_min / load_sec (not while running)
//   load_min  in   8  minutes to load (0..255)
//   load_sec  in   6  seconds to load (values above 59 saturate to 59)
//   start     in   1  strobe: begin / resume counting
//   stop      in   1  strobe: pause counting
//   clear     in   1  strobe: back to IDLE with value 00:00
//   minutes   out  8  minutes remaining
//   seconds   out  6  seconds remaining (0..59)
//   status    out  2  00 IDLE, 01 RUNNING, 10 PAUSED, 11 EXPIRED
//   done      out  1  one-cycle pulse on entry to EXPIRED
//
// Strobe priority within one cycle: clear > load > stop > start.
// All outputs are taken directly from flops.

module countdown_timer #(
  parameter int unsigned TICKS_PER_SEC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_min,
  input  logic [5:0] load_sec,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  output logic [7:0] minutes,
  output logic [5:0] seconds,
  output logic [1:0] status,
  output logic       done
);

  // A one-tick-per-second configuration still needs a 1-bit prescaler.
  localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUNNING = 2'b01,
    ST_PAUSED  = 2'b10,
    ST_EXPIRED = 2'b11
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    min_q, min_d;
  logic [5:0]    sec_q, sec_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          done_q, done_d;

  logic          tick;
  logic          value_zero;
  logic [5:0]    load_sec_sat;

  always_comb begin
    load_sec_sat = (load_sec > 6'd59) ? 6'd59 : load_sec;
    value_zero   = (min_q == '0) && (sec_q == '0);
    tick         = (state_q == ST_RUNNING) && (presc_q == PRESC_LAST);
  end

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    sec_d   = sec_q;
    presc_d = presc_q;
    done_d  = 1'b0;

    if (clear) begin
      state_d = ST_IDLE;
      min_d   = '0;
      sec_d   = '0;
      presc_d = '0;
    end else if (load && (state_q != ST_RUNNING)) begin
      state_d = ST_IDLE;
      min_d   = load_min;
      sec_d   = load_sec_sat;
      presc_d = '0;
    end else if (stop && (state_q == ST_RUNNING)) begin
      // Freeze value and prescaler; a coincident tick is discarded with it.
      state_d = ST_PAUSED;
    end else if (start && !stop && !value_zero &&
                 ((state_q == ST_IDLE) || (state_q == ST_PAUSED))) begin
      // Resume from PAUSED keeps the partial second already counted.
      state_d = ST_RUNNING;
      if (state_q == ST_IDLE) begin
        presc_d = '0;
      end
    end else if (state_q == ST_RUNNING) begin
      if (tick) begin
        presc_d = '0;
        if (sec_q != '0) begin
          sec_d = sec_q - 6'd1;
        end else if (min_q != '0) begin
          min_d = min_q - 8'd1;
          sec_d = 6'd59;
        end
        if ((min_d == '0) && (sec_d == '0)) begin
          state_d = ST_EXPIRED;
          done_d  = 1'b1;
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      min_q   <= '0;
      sec_q   <= '0;
      presc_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      presc_q <= presc_d;
      done_q  <= done_d;
    end
  end

  assign minutes = min_q;
  assign seconds = sec_q;
  assign status  = state_q;
  assign done    = done_q;

endmodule
